alu_issue_stage: RTL and testbench

- Registered issue/result stage that feeds operand pairs and an opcode into the combinational 4-bit gate units (and/or/nor/xor/nand/xnor/add/sub).
- Captures their output into a result register with zero/carry flags.
- Sits directly upstream of the gate units and owns all sequencing.
- Valid/ready handshake on both sides, 2-deep input buffer, one result per cycle sustained.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_core.sv | 46 ++++
 rtl/alu_issue_stage.sv | 136 +++++++++++++
 tb/tb_alu_issue_stage.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Opcode encodings and default widths shared by the ALU issue slice
// Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

  localparam int OP_W      = 3;
  localparam int ALU_WIDTH = 4;

  localparam logic [OP_W-1:0] OP_AND  = 3'b000;
  localparam logic [OP_W-1:0] OP_OR   = 3'b001;
  localparam logic [OP_W-1:0] OP_NOR  = 3'b010;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b011;
  localparam logic [OP_W-1:0] OP_NAND = 3'b100;
  localparam logic [OP_W-1:0] OP_XNOR = 3'b101;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b110;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b111;

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_core
// Purpose  : Combinational gate/adder datapath selected by opcode
// Revision : 1.0  initial release
// ============================================================================
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [OP_W-1:0]  i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry
);

  logic             w_sub;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;

  // Subtraction reuses the adder as A + ~B + 1, so carry-out means no borrow.
  assign w_sub   = (i_op == OP_SUB);
  assign w_b_eff = w_sub ? ~i_b : i_b;
  assign w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};

  always_comb begin
    o_result = '0;
    o_carry  = 1'b0;
    case (i_op)
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_NOR:  o_result = ~(i_a | i_b);
      OP_XOR:  o_result = i_a ^ i_b;
      OP_NAND: o_result = ~(i_a & i_b);
      OP_XNOR: o_result = ~(i_a ^ i_b);
      default: begin
        o_result = w_sum[WIDTH-1:0];
        o_carry  = w_sum[WIDTH];
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Purpose  : Buffered issue stage feeding alu_core, registered result + flags
// Revision : 1.0  initial release
// ============================================================================
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  localparam int c_PTR_W   = $clog2(DEPTH);
  localparam int c_CNT_W   = c_PTR_W + 1;
  localparam int c_ENTRY_W = OP_W + 2 * WIDTH;

  localparam logic [0:0] c_ST_EMPTY = 1'b0;
  localparam logic [0:0] c_ST_FULL  = 1'b1;

  logic [c_ENTRY_W-1:0] r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;

  logic [0:0]           r_state;
  logic [0:0]           w_next_state;
  logic                 w_out_valid;

  logic [WIDTH-1:0]     r_result;
  logic                 r_carry;
  logic                 r_zero;

  logic                 w_push;
  logic                 w_pop;
  logic [c_ENTRY_W-1:0] w_head;
  logic [OP_W-1:0]      w_head_op;
  logic [WIDTH-1:0]     w_head_a;
  logic [WIDTH-1:0]     w_head_b;
  logic [WIDTH-1:0]     w_core_result;
  logic                 w_core_carry;

  // A full FIFO refuses input even when it is popping in the same cycle.
  assign in_ready = !rst && (r_count < c_CNT_W'(DEPTH));
  assign w_push   = in_valid && in_ready;
  assign w_pop    = (r_count != '0) && (!w_out_valid || out_ready);

  assign w_head                           = r_mem[r_rd_ptr];
  assign {w_head_op, w_head_a, w_head_b}  = w_head;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_alu_core (
    .i_op    (w_head_op),
    .i_a     (w_head_a),
    .i_b     (w_head_b),
    .o_result(w_core_result),
    .o_carry (w_core_carry)
  );

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_op, in_A, in_B};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_EMPTY: if (w_pop) w_next_state = c_ST_FULL;
      c_ST_FULL:  if (out_ready && !w_pop) w_next_state = c_ST_EMPTY;
      default:    w_next_state = c_ST_EMPTY;
    endcase
  end

  always_comb begin
    w_out_valid = (r_state == c_ST_FULL);
  end

  // Flags and result hold their last values after a drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_pop) begin
      r_result <= w_core_result;
      r_carry  <= w_core_carry;
      r_zero   <= (w_core_result == '0);
    end
  end

  assign out_valid = w_out_valid;
  assign result    = r_result;
  assign carry     = r_carry;
  assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_stage
// Purpose  : Self-checking bench for alu_issue_stage against a reference model
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_op = '0;
  logic [3:0] in_A = '0;
  logic [3:0] in_B = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] result;
  logic       carry;
  logic       zero;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(
    .WIDTH(4),
    .DEPTH(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_A     (in_A),
    .in_B     (in_B),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .carry    (carry),
    .zero     (zero)
  );

  // Returns {carry, zero, result} computed with plain integer arithmetic.
  function automatic logic [5:0] ref_alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int ia, ib, s;
    logic [3:0] r;
    logic c;
    ia = int'(a);
    ib = int'(b);
    c  = 1'b0;
    r  = '0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = ~(a | b);
      3'd3: r = a ^ b;
      3'd4: r = ~(a & b);
      3'd5: r = ~(a ^ b);
      3'd6: begin s = ia + ib; r = 4'(s % 16);        c = (s > 15);   end
      default: begin s = ia - ib; r = 4'((s + 16) % 16); c = (ia >= ib); end
    endcase
    return {c, (r == 4'd0), r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    in_valid = 1'b0;
    in_op    = 'x;
    in_A     = 'x;
    in_B     = 'x;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    n_total++;
    if ({out_valid, result, carry, zero} !== 7'b0)
      $display("FAIL reset_outputs: got v=%b r=%b c=%b z=%b want all 0", out_valid, result, carry, zero);
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready);
    else n_pass++;
    tick();
    tick();
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready_held: got %b want 0", in_ready);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL release_in_ready: got %b want 1", in_ready);
    else n_pass++;
    tick();
  endtask

  task automatic test_single(input string name, input logic [2:0] op, input logic [3:0] a,
                             input logic [3:0] b, input logic [5:0] exp);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = op;
    in_A      = a;
    in_B      = b;
    tick();
    drive_idle();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL %s_early_valid: got %b want 0", name, out_valid);
    else n_pass++;
    tick();
    n_total++;
    if (out_valid !== 1'b1 || {carry, zero, result} !== exp)
      $display("FAIL %s_result: got v=%b c=%b z=%b r=%b want v=1 c=%b z=%b r=%b",
               name, out_valid, carry, zero, result, exp[5], exp[4], exp[3:0]);
    else n_pass++;
    tick();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL %s_drain: got out_valid=%b want 0", name, out_valid);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [2:0] ops [4];
    logic [5:0] exp [4];
    logic acc;
    ops[0] = 3'd0; ops[1] = 3'd1; ops[2] = 3'd3; ops[3] = 3'd4;
    for (int i = 0; i < 4; i++) exp[i] = ref_alu(ops[i], 4'b1100, 4'b1010);
    out_ready = 1'b0;
    in_A = 4'b1100;
    in_B = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_op    = ops[i];
      tick();
    end
    n_total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || {carry, zero, result} !== exp[0])
      $display("FAIL bp_fill: got rdy=%b v=%b res=%b want rdy=0 v=1 res=%b",
               in_ready, out_valid, {carry, zero, result}, exp[0]);
    else n_pass++;
    in_op = ops[3];
    repeat (3) tick();
    n_total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || {carry, zero, result} !== exp[0])
      $display("FAIL bp_hold: got rdy=%b v=%b res=%b want rdy=0 v=1 res=%b",
               in_ready, out_valid, {carry, zero, result}, exp[0]);
    else n_pass++;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (out_valid !== 1'b1 || {carry, zero, result} !== exp[k])
        $display("FAIL bp_drain_%0d: got v=%b res=%b want v=1 res=%b", k, out_valid, {carry, zero, result}, exp[k]);
      else n_pass++;
      acc = in_valid && in_ready;
      tick();
      if (acc) drive_idle();
    end
    n_total++;
    if (out_valid !== 1'b0 || in_valid !== 1'b0)
      $display("FAIL bp_empty: got v=%b pending_in=%b want 0 0", out_valid, in_valid);
    else n_pass++;
  endtask

  task automatic test_stream();
    logic [5:0] q [$];
    logic [5:0] e;
    int sent = 0, got = 0, run = 0, max_run = 0, drops = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (sent < 8) begin
        in_valid = 1'b1;
        in_op    = 3'($urandom_range(0, 7));
        in_A     = 4'($urandom_range(0, 15));
        in_B     = 4'($urandom_range(0, 15));
        if (in_ready !== 1'b1) drops++;
      end else drive_idle();
      if (out_valid === 1'b1) begin
        run++;
        if (run > max_run) max_run = run;
        got++;
        n_total++;
        if (q.size() == 0) $display("FAIL stream_extra: unexpected result %b", {carry, zero, result});
        else begin
          e = q.pop_front();
          if ({carry, zero, result} !== e) $display("FAIL stream_order: got %b want %b", {carry, zero, result}, e);
          else n_pass++;
        end
      end else run = 0;
      if (in_valid && in_ready) begin
        q.push_back(ref_alu(in_op, in_A, in_B));
        sent++;
      end
      tick();
    end
    n_total++;
    if (got != 8 || max_run != 8 || drops != 0)
      $display("FAIL stream_rate: got results=%0d run=%0d ready_drops=%0d want 8 8 0", got, max_run, drops);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [5:0] q [$];
    logic [5:0] e, held;
    logic hold = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) begin
        in_valid = 1'b1;
        in_op    = 3'($urandom_range(0, 7));
        in_A     = 4'($urandom_range(0, 15));
        in_B     = 4'($urandom_range(0, 15));
      end else drive_idle();
      if (hold) begin
        n_total++;
        if (out_valid !== 1'b1 || {carry, zero, result} !== held)
          $display("FAIL rand_stall: got v=%b res=%b want v=1 res=%b", out_valid, {carry, zero, result}, held);
        else n_pass++;
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_total++;
        if (q.size() == 0) $display("FAIL rand_extra: unexpected result %b", {carry, zero, result});
        else begin
          e = q.pop_front();
          if ({carry, zero, result} !== e) $display("FAIL rand_order: got %b want %b", {carry, zero, result}, e);
          else n_pass++;
        end
      end
      hold = (out_valid === 1'b1) && !out_ready;
      held = {carry, zero, result};
      if (in_valid && in_ready) q.push_back(ref_alu(in_op, in_A, in_B));
      tick();
    end
    drive_idle();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10 && q.size() != 0; cyc++) begin
      if (out_valid === 1'b1) begin
        n_total++;
        e = q.pop_front();
        if ({carry, zero, result} !== e) $display("FAIL rand_drain: got %b want %b", {carry, zero, result}, e);
        else n_pass++;
      end
      tick();
    end
    n_total++;
    if (q.size() != 0 || out_valid !== 1'b0)
      $display("FAIL rand_leftover: got %0d pending v=%b want 0 pending v=0", q.size(), out_valid);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int stale = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op = 3'd6; in_A = 4'b1111; in_B = 4'b0011;
    tick();
    in_op = 3'd1; in_A = 4'b0101; in_B = 4'b1010;
    tick();
    in_op = 3'd5; in_A = 4'b0001; in_B = 4'b0010;
    tick();
    drive_idle();
    n_total++;
    if (out_valid !== 1'b1 || {carry, zero, result} !== 6'b100010 || in_ready !== 1'b0)
      $display("FAIL arst_setup: got v=%b res=%b rdy=%b want v=1 res=100010 rdy=0",
               out_valid, {carry, zero, result}, in_ready);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({out_valid, result, carry, zero} !== 7'b0 || in_ready !== 1'b0)
      $display("FAIL arst_immediate: got v=%b r=%b c=%b z=%b rdy=%b want all 0",
               out_valid, result, carry, zero, in_ready);
    else n_pass++;
    tick();
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL arst_in_ready: got %b want 0", in_ready);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      if (out_valid !== 1'b0) stale++;
      tick();
    end
    n_total++;
    if (stale != 0 || in_ready !== 1'b1)
      $display("FAIL arst_stale: got %0d stale cycles rdy=%b want 0 and rdy=1", stale, in_ready);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single("nor_basic", 3'b010, 4'b1001, 4'b1010, 6'b000100);
    test_single("nor_zero",  3'b010, 4'b0000, 4'b1111, 6'b010000);
    test_single("add_wrap",  3'b110, 4'b1111, 4'b0001, 6'b110000);
    test_single("sub_borrow", 3'b111, 4'b0011, 4'b0101, 6'b001110);
    test_single("sub_noborrow", 3'b111, 4'b0101, 4'b0011, 6'b100010);
    test_backpressure();
    test_stream();
    test_random();
    test_async_reset();
    test_single("post_reset", 3'b011, 4'b1010, 4'b0110, 6'b001100);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
